// File: rtl/reduce_pkg.sv
// Shared types for the reduce_gate_reg block: op encodings and the
// two-state occupancy of the result register.
package reduce_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND  = 2'd0;
   localparam op_t OP_OR   = 2'd1;
   localparam op_t OP_XOR  = 2'd2;
   localparam op_t OP_NAND = 2'd3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/reduce_gate_reg_if.sv
// Valid/ready handshake bundle for reduce_gate_reg; master drives the
// input word and out_ready, slave is the reduction unit.
interface reduce_gate_reg_if
   import reduce_pkg::*;
#(
   parameter int N = 3
);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   op_t          op;
   logic         out_valid;
   logic         out_ready;
   logic         out_data;
   op_t          out_op;

   modport master (
      output in_valid, in_data, op, out_ready,
      input  in_ready, out_valid, out_data, out_op
   );

   modport slave (
      input  in_valid, in_data, op, out_ready,
      output in_ready, out_valid, out_data, out_op
   );

endinterface

// File: rtl/reduce_core.sv
// Combinational N-input reduction selected by op.
module reduce_core
   import reduce_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0] data,
   input  op_t          op,
   output logic         y
);

   always_comb begin
      y = 1'b0;
      case (op)
         OP_AND:  y = &data;
         OP_OR:   y = |data;
         OP_XOR:  y = ^data;
         OP_NAND: y = ~&data;
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/reduce_gate_reg.sv
// Registered N-input reduction with valid/ready on both sides and a
// saturating count of delivered results equal to 1.
//
//   state    | meaning
//   ST_EMPTY | result register holds nothing undelivered (out_valid=0)
//   ST_FULL  | result register holds an undelivered result (out_valid=1)
module reduce_gate_reg
   import reduce_pkg::*;
#(
   parameter int N     = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   reduce_gate_reg_if.slave bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state_q;
   state_t state_d;
   logic   accept;
   logic   deliver;
   logic   y;
   logic   data_q;
   op_t    op_q;

   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.in_ready  = !bus.out_valid || bus.out_ready;
   assign bus.out_data  = data_q;
   assign bus.out_op    = op_q;

   assign accept  = bus.in_valid && bus.in_ready;
   assign deliver = bus.out_valid && bus.out_ready;

   reduce_core #(.N(N)) u_core (
      .data (bus.in_data),
      .op   (bus.op),
      .y    (y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (deliver && !accept) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Result register only loads on accept, so a stall or a plain deliver
   // leaves the last result visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 1'b0;
         op_q   <= OP_AND;
      end else if (accept) begin
         data_q <= y;
         op_q   <= bus.op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hit_cnt <= '0;
      else if (clr_cnt)
         hit_cnt <= '0;
      else if (deliver && data_q && (hit_cnt != CNT_MAX))
         hit_cnt <= hit_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_reduce_gate_reg.sv
// Self-checking bench for reduce_gate_reg: vector tables, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_reduce_gate_reg;

   typedef struct {
      logic [1:0] op;
      logic [7:0] data;
      logic       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // main build N=3, CNT_W=8
   reduce_gate_reg_if #(.N(3)) bus3 ();
   logic       clr3 = 1'b0;
   logic [7:0] hit3;
   reduce_gate_reg #(.N(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3), .clr_cnt(clr3), .hit_cnt(hit3));

   // saturation build CNT_W=2
   reduce_gate_reg_if #(.N(3)) bus_s ();
   logic       clr_s = 1'b0;
   logic [1:0] hit_s;
   reduce_gate_reg #(.N(3), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s), .clr_cnt(clr_s), .hit_cnt(hit_s));

   reduce_gate_reg_if #(.N(1)) bus1 ();
   logic [7:0] hit1;
   reduce_gate_reg #(.N(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .clr_cnt(1'b0), .hit_cnt(hit1));

   reduce_gate_reg_if #(.N(8)) bus8 ();
   logic [7:0] hit8;
   reduce_gate_reg #(.N(8), .CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8), .clr_cnt(1'b0), .hit_cnt(hit8));

   // behavioural model of the main build
   logic       m_valid = 1'b0;
   logic       m_data  = 1'b0;
   logic [1:0] m_op    = 2'd0;
   int         m_cnt   = 0;
   localparam int CMAX3 = 255;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic ref_reduce(input logic [1:0] op, input int ones, input int n);
      case (op)
         2'd0:    return ones == n;
         2'd1:    return ones != 0;
         2'd2:    return (ones % 2) == 1;
         default: return ones != n;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // advance one edge on the main build, updating the model from the
   // inputs presented before the edge
   task automatic cyc3();
      logic rdy, acc, dlv;
      rdy = !m_valid || bus3.out_ready;
      acc = bus3.in_valid && rdy;
      dlv = m_valid && bus3.out_ready;
      if (clr3) m_cnt = 0;
      else if (dlv && m_data && m_cnt < CMAX3) m_cnt++;
      if (acc) begin
         m_data  = ref_reduce(bus3.op, $countones(bus3.in_data), 3);
         m_op    = bus3.op;
         m_valid = 1'b1;
      end else if (dlv) begin
         m_valid = 1'b0;
      end
      step();
   endtask

   task automatic check3(input string name);
      chk({name, " out_valid"}, bus3.out_valid, m_valid);
      chk({name, " in_ready"}, bus3.in_ready, !m_valid || bus3.out_ready);
      chk({name, " out_data"}, bus3.out_data, m_data);
      chk({name, " out_op"}, bus3.out_op, m_op);
      chk({name, " hit_cnt"}, hit3, m_cnt);
   endtask

   vec_t t3[14];
   vec_t t1[5];
   vec_t t8[4];

   initial begin
      for (int i = 0; i < 8; i++) t3[i] = '{2'd0, 8'(i), (i == 7)};
      t3[8]  = '{2'd1, 8'b000, 1'b0};
      t3[9]  = '{2'd1, 8'b100, 1'b1};
      t3[10] = '{2'd2, 8'b101, 1'b0};
      t3[11] = '{2'd2, 8'b111, 1'b1};
      t3[12] = '{2'd3, 8'b111, 1'b0};
      t3[13] = '{2'd3, 8'b011, 1'b1};

      t1[0] = '{2'd0, 8'd1, 1'b1};
      t1[1] = '{2'd1, 8'd1, 1'b1};
      t1[2] = '{2'd2, 8'd1, 1'b1};
      t1[3] = '{2'd3, 8'd1, 1'b0};
      t1[4] = '{2'd3, 8'd0, 1'b1};

      t8[0] = '{2'd2, 8'b1011_0001, 1'b0};
      t8[1] = '{2'd0, 8'hFF, 1'b1};
      t8[2] = '{2'd1, 8'h00, 1'b0};
      t8[3] = '{2'd3, 8'h7F, 1'b1};

      bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.op = 2'd0; bus3.in_data = '0;
      bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b0; bus_s.op = 2'd0; bus_s.in_data = '0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.op = 2'd0; bus1.in_data = '0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.op = 2'd0; bus8.in_data = '0;

      #12 rst_n = 1'b1;
      step();
      check3("reset");
      chk("reset hit_s", hit_s, 0);

      // N=1 build
      bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus1.op = t1[i].op; bus1.in_data = t1[i].data[0];
         step();
         chk($sformatf("n1 vec%0d out_data", i), bus1.out_data, t1[i].exp);
         chk($sformatf("n1 vec%0d in_ready", i), bus1.in_ready, 1'b1);
      end
      bus1.in_valid = 1'b0;

      // N=8 build
      bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus8.op = t8[i].op; bus8.in_data = t8[i].data;
         step();
         chk($sformatf("n8 vec%0d out_data", i), bus8.out_data, t8[i].exp);
         chk($sformatf("n8 vec%0d out_op", i), bus8.out_op, t8[i].op);
      end
      bus8.in_valid = 1'b0;

      // saturation on CNT_W=2
      bus_s.in_valid = 1'b1; bus_s.out_ready = 1'b1; bus_s.op = 2'd0; bus_s.in_data = 3'b111;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("sat deliver%0d hit_cnt", i), hit_s, (i < 3) ? i + 1 : 3);
      end
      clr_s = 1'b1;
      step();
      clr_s = 1'b0;
      chk("sat clr hit_cnt", hit_s, 0);
      chk("sat clr out_valid", bus_s.out_valid, 1'b1);
      bus_s.in_valid = 1'b0;

      // table: AND sweep then mixed ops, full throughput
      bus3.out_ready = 1'b1; bus3.in_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         bus3.op = t3[i].op; bus3.in_data = t3[i].data[2:0];
         cyc3();
         chk($sformatf("tbl%0d out_data", i), bus3.out_data, t3[i].exp);
         chk($sformatf("tbl%0d out_op", i), bus3.out_op, t3[i].op);
         check3($sformatf("tbl%0d", i));
      end
      chk("tbl hit_cnt", hit3, 3);

      // backpressure
      bus3.in_valid = 1'b0;
      cyc3();
      bus3.out_ready = 1'b0; bus3.in_valid = 1'b1; bus3.op = 2'd0; bus3.in_data = 3'b111;
      cyc3();
      chk("bp accept out_valid", bus3.out_valid, 1'b1);
      chk("bp accept in_ready", bus3.in_ready, 1'b0);
      chk("bp accept out_data", bus3.out_data, 1'b1);
      bus3.op = 2'd1; bus3.in_data = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cyc3();
         chk($sformatf("bp stall%0d out_data", i), bus3.out_data, 1'b1);
         check3($sformatf("bp stall%0d", i));
      end
      bus3.out_ready = 1'b1;
      cyc3();
      chk("bp release out_valid", bus3.out_valid, 1'b1);
      chk("bp release out_data", bus3.out_data, 1'b0);
      chk("bp release out_op", bus3.out_op, 2'd1);
      check3("bp release");

      // async reset during a stall with hit_cnt=2
      bus3.in_valid = 1'b0; clr3 = 1'b1;
      cyc3();
      clr3 = 1'b0; bus3.in_valid = 1'b1; bus3.op = 2'd0; bus3.in_data = 3'b111;
      cyc3(); cyc3(); cyc3();
      bus3.out_ready = 1'b0; bus3.in_valid = 1'b0;
      cyc3();
      chk("rst pre hit_cnt", hit3, 2);
      chk("rst pre out_valid", bus3.out_valid, 1'b1);
      chk("rst pre out_data", bus3.out_data, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async out_valid", bus3.out_valid, 1'b0);
      chk("rst async out_data", bus3.out_data, 1'b0);
      chk("rst async out_op", bus3.out_op, 2'd0);
      chk("rst async hit_cnt", hit3, 0);
      chk("rst async in_ready", bus3.in_ready, 1'b1);
      #1 rst_n = 1'b1;
      m_valid = 1'b0; m_data = 1'b0; m_op = 2'd0; m_cnt = 0;
      cyc3();
      check3("rst after");

      // randomized traffic, X on the inputs while idle
      for (int i = 0; i < 400; i++) begin
         bus3.in_valid  = ($urandom_range(0, 3) != 0);
         bus3.out_ready = ($urandom_range(0, 3) != 0);
         clr3           = ($urandom_range(0, 15) == 0);
         if (bus3.in_valid) begin
            bus3.op      = 2'($urandom);
            bus3.in_data = 3'($urandom);
         end else begin
            bus3.op      = 'x;
            bus3.in_data = 'x;
         end
         cyc3();
         check3($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reduce_gate_reg.md
Name: reduce_gate_reg

Overview:
Parametrised, registered N-input logic reduction unit. It generalises the fixed 3-input AND gate to N inputs and four run-time selectable operations. A valid/ready handshake on both sides allows placement between pipeline stages, and an output register holds results under backpressure. A saturating counter tracks how many delivered results were 1.

Parameters:
N, 3, number of input bits reduced (N >= 1)
CNT_W, 8, width of the hit counter (CNT_W >= 1)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word present
in_ready  out  1  unit can accept this cycle
in_data  in  N  bits to reduce
op  in  2  operation, sampled with in_data: 0 AND, 1 OR, 2 XOR, 3 NAND
out_valid  out  1  result register holds an undelivered result
out_ready  in  1  downstream accepts result
out_data  out  1  reduction result
out_op  out  2  op that produced out_data
clr_cnt  in  1  synchronous clear of hit_cnt
hit_cnt  out  CNT_W  saturating count of delivered results equal to 1

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, independent of clk): out_valid=0, out_data=0, out_op=0, hit_cnt=0. in_ready=1 while in reset follows from out_valid=0. Release is synchronous to clk.
- in_ready = !out_valid || out_ready. This is combinational, with no dependency on in_valid.
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- On accept at edge k: out_data <= reduce(op, in_data), out_op <= op, out_valid <= 1, visible after edge k. Latency is 1 cycle.
- On deliver without accept: out_valid <= 0. out_data and out_op keep their last values.
- Simultaneous deliver and accept: the register is overwritten with the new result and out_valid stays 1. Full throughput is 1 result/cycle.
- Stall (out_valid && !out_ready): out_data and out_op are held stable. in_ready=0, so in_data and op are ignored.
- Reduction rules:
  - AND is &in_data, OR is |in_data, XOR is ^in_data (odd parity), NAND is ~&in_data.
  - For N=1, AND, OR and XOR all equal in_data[0], and NAND equals ~in_data[0].
- hit_cnt:
  - On a deliver with out_data=1, hit_cnt increments by 1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt=1 forces hit_cnt to 0 at the edge, overriding a coincident increment.
- X on in_data or op while in_valid=0 has no effect on any output.
- No internal state other than the result register, out_valid and hit_cnt. No FSM beyond the two-state EMPTY/FULL encoded by out_valid:
  - EMPTY goes to FULL on accept.
  - FULL goes to EMPTY on deliver without accept.
  - FULL stays FULL on stall, or on deliver with accept.

Decomposition:
- Shared package reduce_pkg:
  - op encodings as localparams OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_NAND=2'd3.
  - a typedef for the 2-bit op field.
- One combinational sub-module, reduce_core (params N; in: data[N-1:0], op; out: y), instantiated once. The top holds the handshake, result register and counter.

Test Plan:
1. N=3, op=AND, out_ready=1, in_valid=1, sweep in_data 000..111 one per cycle -> out_data is 0 for 000..110 and 1 for 111, each one cycle after accept. out_valid stays 1 throughout. hit_cnt=1 after the last deliver.
2. N=3, op sequence with in_data: OR 000 -> 0, OR 100 -> 1, XOR 101 -> 0, XOR 111 -> 1, NAND 111 -> 0, NAND 011 -> 1. out_op echoes each op.
3. Backpressure:
   - out_ready=0, accept AND 111 -> out_valid=1, in_ready=0, out_data=1.
   - Then offer OR 000 for 3 cycles -> not accepted, out_data stays 1.
   - Then raise out_ready -> the same edge delivers 1 and accepts OR 000, out_valid stays 1, out_data=0 on the next cycle.
4. Saturation, CNT_W=2: deliver five results of 1 -> hit_cnt goes 1, 2, 3, 3, 3. Then clr_cnt=1 on the same cycle as a deliver of 1 -> hit_cnt=0.
5. Asynchronous reset during a stall: out_valid=1, out_data=1, hit_cnt=2, pulse rst_n low mid-cycle -> out_valid, out_data, out_op and hit_cnt are 0 before the next clk edge, and in_ready=1.
6. N=1 and N=8 builds:
   - N=1, in_data=1 -> AND, OR and XOR give 1, NAND gives 0.
   - N=8, XOR 8'b1011_0001 -> 0, AND 8'hFF -> 1, OR 8'h00 -> 0.
